// File: rtl/stego_crypt_engine_pkg.sv
// rtl/stego_crypt_engine_pkg.sv - shared types and helpers for the stego crypt engine
package stego_crypt_engine_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_EMBED   = 1'b0;
  localparam logic MODE_EXTRACT = 1'b1;

  function automatic bit legal_embed_w(input int w);
    return (w == 1) || (w == 2) || (w == 4);
  endfunction

endpackage

// File: rtl/stego_crypt_engine_key_ram.sv
// rtl/stego_crypt_engine_key_ram.sv - nibble-wide key store, one write port, async read
module key_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [3:0]    rd_data
);

  // No reset: key contents survive an engine reset.
  logic [3:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stego_crypt_engine.sv
// rtl/stego_crypt_engine.sv - LSB steganography embed/extract with XOR key stream
module stego_crypt_engine
  import stego_crypt_engine_pkg::*;
#(
  parameter int EMBED_W = 1,
  parameter int KEY_AW  = 8,
  parameter int LEN_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_mode,
  input  logic [LEN_W-1:0]  cfg_msg_nibbles,
  input  logic [KEY_AW:0]   cfg_key_len,
  input  logic              key_wr_en,
  input  logic [KEY_AW-1:0] key_wr_addr,
  input  logic [3:0]        key_wr_data,
  input  logic              pix_in_valid,
  output logic              pix_in_ready,
  input  logic [7:0]        pix_in_data,
  input  logic              pix_in_last,
  input  logic              txt_in_valid,
  output logic              txt_in_ready,
  input  logic [3:0]        txt_in_data,
  output logic              pix_out_valid,
  input  logic              pix_out_ready,
  output logic [7:0]        pix_out_data,
  output logic              pix_out_last,
  output logic              txt_out_valid,
  input  logic              txt_out_ready,
  output logic [3:0]        txt_out_data,
  output logic              busy,
  output logic              done,
  output logic              msg_trunc
);

  if (!legal_embed_w(EMBED_W)) begin : g_bad_embed_w
    $error("EMBED_W must be 1, 2 or 4");
  end

  localparam int         SLICES     = 4 / EMBED_W;
  localparam logic [1:0] LAST_SLICE = 2'(SLICES - 1);
  localparam logic [7:0] MASK       = 8'((1 << EMBED_W) - 1);

  state_t              state, state_nx;
  logic                mode;
  logic [LEN_W-1:0]    msg_len, nib_cnt;
  logic [KEY_AW:0]     key_len, kidx_inc;
  logic [KEY_AW-1:0]   kidx;
  logic [1:0]          slice;
  logic [3:0]          enc_reg, acc, acc_nx, enc_now, key_rd, key_nib, shamt;
  logic [7:0]          pix_mod;
  logic                active, last_slice, base_ok, pix_acc, nib_done, trunc_now;

  key_ram #(.AW(KEY_AW)) u_key_ram (
    .clk     (clk),
    .wr_en   (key_wr_en && (state == IDLE)),
    .wr_addr (key_wr_addr),
    .wr_data (key_wr_data),
    .rd_addr (kidx),
    .rd_data (key_rd)
  );

  always_comb begin
    state_nx     = state;
    pix_in_ready = 1'b0;
    txt_in_ready = 1'b0;
    key_nib      = (key_len == '0) ? 4'h0 : key_rd;
    active       = nib_cnt < msg_len;
    last_slice   = slice == LAST_SLICE;
    base_ok      = (state == RUN) && (!pix_out_valid || pix_out_ready);
    // Embed couples the first slice of each nibble to a text transfer.
    if (base_ok) begin
      if (mode == MODE_EMBED && active && slice == 2'd0) begin
        pix_in_ready = txt_in_valid;
        txt_in_ready = pix_in_valid;
      end else if (mode == MODE_EXTRACT && active && last_slice && txt_out_valid && !txt_out_ready) begin
        pix_in_ready = 1'b0;
      end else begin
        pix_in_ready = 1'b1;
      end
    end
    pix_acc   = pix_in_valid && pix_in_ready;
    shamt     = 4'(slice * EMBED_W);
    enc_now   = (slice == 2'd0) ? (txt_in_data ^ key_nib) : enc_reg;
    pix_mod   = (pix_in_data & ~MASK) | ({4'h0, enc_now >> shamt} & MASK);
    acc_nx    = acc | 4'((pix_in_data & MASK) << shamt);
    nib_done  = pix_acc && active && last_slice;
    trunc_now = pix_acc && pix_in_last && active && !(nib_done && (nib_cnt + 1'b1) == msg_len);
    kidx_inc  = {1'b0, kidx} + 1'b1;
    case (state)
      IDLE:    if (cfg_start) state_nx = RUN;
      RUN:     if (pix_acc && pix_in_last) state_nx = DRAIN;
      DRAIN:   if (!pix_out_valid && !txt_out_valid) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = state != IDLE;
  assign done = state == DONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mode          <= MODE_EMBED;
      msg_len       <= '0;
      key_len       <= '0;
      nib_cnt       <= '0;
      kidx          <= '0;
      slice         <= '0;
      enc_reg       <= '0;
      acc           <= '0;
      pix_out_valid <= 1'b0;
      pix_out_data  <= '0;
      pix_out_last  <= 1'b0;
      txt_out_valid <= 1'b0;
      txt_out_data  <= '0;
      msg_trunc     <= 1'b0;
    end else begin
      state <= state_nx;
      if (pix_out_valid && pix_out_ready) pix_out_valid <= 1'b0;
      if (txt_out_valid && txt_out_ready) txt_out_valid <= 1'b0;
      if (state == IDLE && cfg_start) begin
        mode      <= cfg_mode;
        msg_len   <= cfg_msg_nibbles;
        key_len   <= cfg_key_len;
        nib_cnt   <= '0;
        kidx      <= '0;
        slice     <= '0;
        acc       <= '0;
        msg_trunc <= 1'b0;
      end
      if (pix_acc) begin
        pix_out_valid <= 1'b1;
        pix_out_last  <= pix_in_last;
        pix_out_data  <= (mode == MODE_EMBED && active) ? pix_mod : pix_in_data;
        if (active && slice == 2'd0) enc_reg <= enc_now;
        if (nib_done) begin
          slice   <= '0;
          acc     <= '0;
          nib_cnt <= nib_cnt + 1'b1;
          kidx    <= (kidx_inc >= key_len) ? '0 : kidx_inc[KEY_AW-1:0];
          if (mode == MODE_EXTRACT) begin
            txt_out_valid <= 1'b1;
            txt_out_data  <= acc_nx ^ key_nib;
          end
        end else if (active) begin
          slice <= slice + 1'b1;
          acc   <= acc_nx;
        end
        // A frame end drops any partially assembled nibble.
        if (pix_in_last) begin
          slice <= '0;
          acc   <= '0;
        end
        if (trunc_now) msg_trunc <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stego_crypt_engine.sv
// tb/tb_stego_crypt_engine.sv - scoreboard bench for stego_crypt_engine
module tb_stego_crypt_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  start = '0;
  logic        cfg_mode = 1'b0;
  logic [15:0] cfg_msg = '0;
  logic [8:0]  cfg_klen = '0;
  logic        key_we = 1'b0;
  logic [7:0]  key_wa = '0;
  logic [3:0]  key_wd = '0;
  logic        piv = 1'b0, pil = 1'b0, tiv = 1'b0;
  logic [7:0]  pid = '0;
  logic [3:0]  tid = '0;
  logic        pout_rdy = 1'b1, tout_rdy = 1'b1;

  logic [1:0]  pir, tir, pov, pol, tov, busy, done, trunc;
  logic [7:0]  pod [2];
  logic [3:0]  tod [2];

  int checks = 0;
  int errors = 0;
  logic [8:0] pq0 [$];
  logic [8:0] pq1 [$];
  logic [3:0] tq1 [$];
  logic [8:0] e9;
  logic [3:0] e4;
  logic       hold0 = 1'b0, hold1 = 1'b0;

  always #5 clk = ~clk;

  stego_crypt_engine #(.EMBED_W(1), .KEY_AW(8), .LEN_W(16)) u_dut_w1 (
    .clk(clk), .reset(rst), .cfg_start(start[0]), .cfg_mode(cfg_mode),
    .cfg_msg_nibbles(cfg_msg), .cfg_key_len(cfg_klen),
    .key_wr_en(key_we), .key_wr_addr(key_wa), .key_wr_data(key_wd),
    .pix_in_valid(piv), .pix_in_ready(pir[0]), .pix_in_data(pid), .pix_in_last(pil),
    .txt_in_valid(tiv), .txt_in_ready(tir[0]), .txt_in_data(tid),
    .pix_out_valid(pov[0]), .pix_out_ready(pout_rdy), .pix_out_data(pod[0]), .pix_out_last(pol[0]),
    .txt_out_valid(tov[0]), .txt_out_ready(tout_rdy), .txt_out_data(tod[0]),
    .busy(busy[0]), .done(done[0]), .msg_trunc(trunc[0])
  );

  stego_crypt_engine #(.EMBED_W(4), .KEY_AW(8), .LEN_W(16)) u_dut_w4 (
    .clk(clk), .reset(rst), .cfg_start(start[1]), .cfg_mode(cfg_mode),
    .cfg_msg_nibbles(cfg_msg), .cfg_key_len(cfg_klen),
    .key_wr_en(key_we), .key_wr_addr(key_wa), .key_wr_data(key_wd),
    .pix_in_valid(piv), .pix_in_ready(pir[1]), .pix_in_data(pid), .pix_in_last(pil),
    .txt_in_valid(tiv), .txt_in_ready(tir[1]), .txt_in_data(tid),
    .pix_out_valid(pov[1]), .pix_out_ready(pout_rdy), .pix_out_data(pod[1]), .pix_out_last(pol[1]),
    .txt_out_valid(tov[1]), .txt_out_ready(tout_rdy), .txt_out_data(tod[1]),
    .busy(busy[1]), .done(done[1]), .msg_trunc(trunc[1])
  );

  // Monitor: pops the scoreboard on every output transfer, independent of stimulus.
  always @(negedge clk) begin
    if (hold0) begin
      checks++;
      if (!pov[0]) begin errors++; $display("FAIL w1_valid_hold: pix_out_valid dropped without transfer"); end
    end
    if (hold1) begin
      checks++;
      if (!pov[1]) begin errors++; $display("FAIL w4_valid_hold: pix_out_valid dropped without transfer"); end
    end
    hold0 = pov[0] && !pout_rdy;
    hold1 = pov[1] && !pout_rdy;
    if (pov[0] && pout_rdy) begin
      checks++;
      if (pq0.size() == 0) begin
        errors++; $display("FAIL w1_pix_out: got %h last=%b, expected nothing", pod[0], pol[0]);
      end else begin
        e9 = pq0.pop_front();
        if ({pol[0], pod[0]} !== e9) begin
          errors++; $display("FAIL w1_pix_out: got last=%b data=%h, expected last=%b data=%h", pol[0], pod[0], e9[8], e9[7:0]);
        end
      end
    end
    if (pov[1] && pout_rdy) begin
      checks++;
      if (pq1.size() == 0) begin
        errors++; $display("FAIL w4_pix_out: got %h last=%b, expected nothing", pod[1], pol[1]);
      end else begin
        e9 = pq1.pop_front();
        if ({pol[1], pod[1]} !== e9) begin
          errors++; $display("FAIL w4_pix_out: got last=%b data=%h, expected last=%b data=%h", pol[1], pod[1], e9[8], e9[7:0]);
        end
      end
    end
    if (tov[0] && tout_rdy) begin
      checks++; errors++; $display("FAIL w1_txt_out: got %h, expected nothing", tod[0]);
    end
    if (tov[1] && tout_rdy) begin
      checks++;
      if (tq1.size() == 0) begin
        errors++; $display("FAIL w4_txt_out: got %h, expected nothing", tod[1]);
      end else begin
        e4 = tq1.pop_front();
        if (tod[1] !== e4) begin errors++; $display("FAIL w4_txt_out: got %h, expected %h", tod[1], e4); end
      end
    end
  end

  task automatic write_key(input logic [7:0] a, input logic [3:0] d);
    key_we = 1'b1; key_wa = a; key_wd = d;
    @(posedge clk); #1;
    key_we = 1'b0;
  endtask

  task automatic start_frame(input int s, input logic m, input logic [15:0] n, input logic [8:0] kl);
    cfg_mode = m; cfg_msg = n; cfg_klen = kl;
    start[s] = 1'b1;
    @(posedge clk); #1;
    start = '0;
  endtask

  task automatic send_pix(input int s, input logic [7:0] d, input logic l, input logic ht,
                          input logic [3:0] t, input logic [7:0] expd);
    int n = 0;
    if (s == 0) pq0.push_back({l, expd}); else pq1.push_back({l, expd});
    piv = 1'b1; pid = d; pil = l; tiv = ht; tid = t;
    @(negedge clk);
    while (!pir[s] && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200) begin
      errors++; $display("FAIL pix_in_timeout: dut=%0d pixel %h never accepted", s, d);
    end else if (tir[s] !== ht) begin
      errors++; $display("FAIL txt_in_ready: dut=%0d pixel %h got %b, expected %b", s, d, tir[s], ht);
    end
    @(posedge clk); #1;
    piv = 1'b0; tiv = 1'b0; pil = 1'b0;
  endtask

  task automatic wait_done(input int s, input logic tr);
    int n = 0;
    @(negedge clk);
    while (!done[s] && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n >= 100) begin
      errors++; $display("FAIL done_timeout: dut=%0d done never seen", s);
    end else if (trunc[s] !== tr) begin
      errors++; $display("FAIL msg_trunc: dut=%0d got %b, expected %b", s, trunc[s], tr);
    end
    @(negedge clk);
    checks++;
    if ({done[s], busy[s], trunc[s]} !== {1'b0, 1'b0, tr}) begin
      errors++; $display("FAIL after_done: dut=%0d done/busy/trunc got %b%b%b, expected 00%b", s, done[s], busy[s], trunc[s], tr);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_basic_w1();
    start_frame(0, 1'b0, 16'd1, 9'd1);
    send_pix(0, 8'h10, 1'b0, 1'b1, 4'h5, 8'h11);
    send_pix(0, 8'h11, 1'b0, 1'b0, 4'h0, 8'h11);
    send_pix(0, 8'h12, 1'b0, 1'b0, 4'h0, 8'h13);
    send_pix(0, 8'h13, 1'b1, 1'b0, 4'h0, 8'h13);
    wait_done(0, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({pir, tir, pov, tov, busy, done, trunc} !== '0) begin
      errors++;
      $display("FAIL %s: ready/valid/status got %b, expected all zero", tag, {pir, tir, pov, tov, busy, done, trunc});
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;
    write_key(8'd0, 4'hA);

    run_basic_w1();

    // Two nibbles (0x5, 0x3) across 8 pixels, output stalled 5 cycles mid-frame.
    start_frame(0, 1'b0, 16'd2, 9'd1);
    fork
      begin
        send_pix(0, 8'h20, 1'b0, 1'b1, 4'h5, 8'h21);
        send_pix(0, 8'h21, 1'b0, 1'b0, 4'h0, 8'h21);
        send_pix(0, 8'h22, 1'b0, 1'b0, 4'h0, 8'h23);
        send_pix(0, 8'h23, 1'b0, 1'b0, 4'h0, 8'h23);
        send_pix(0, 8'h24, 1'b0, 1'b1, 4'h3, 8'h25);
        send_pix(0, 8'h25, 1'b0, 1'b0, 4'h0, 8'h24);
        send_pix(0, 8'h26, 1'b0, 1'b0, 4'h0, 8'h26);
        send_pix(0, 8'h27, 1'b1, 1'b0, 4'h0, 8'h27);
      end
      begin
        repeat (3) @(posedge clk);
        #1 pout_rdy = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (pir[0] !== 1'b0) begin errors++; $display("FAIL stall_ready: pix_in_ready got %b, expected 0", pir[0]); end
        end
        @(posedge clk); #1 pout_rdy = 1'b1;
      end
    join
    wait_done(0, 1'b0);

    // Abort mid-frame, then rerun with the retained key.
    start_frame(0, 1'b0, 16'd1, 9'd1);
    send_pix(0, 8'h10, 1'b0, 1'b1, 4'h5, 8'h11);
    send_pix(0, 8'h11, 1'b0, 1'b0, 4'h0, 8'h11);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_run_reset");
    pq0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_basic_w1();

    write_key(8'd0, 4'h5);
    start_frame(1, 1'b0, 16'd1, 9'd1);
    send_pix(1, 8'hAB, 1'b1, 1'b1, 4'h3, 8'hA6);
    wait_done(1, 1'b0);
    start_frame(1, 1'b1, 16'd1, 9'd1);
    tq1.push_back(4'h3);
    send_pix(1, 8'hA6, 1'b1, 1'b0, 4'h0, 8'hA6);
    wait_done(1, 1'b0);

    write_key(8'd0, 4'h1);
    write_key(8'd1, 4'h2);
    start_frame(1, 1'b0, 16'd3, 9'd2);
    send_pix(1, 8'h50, 1'b0, 1'b1, 4'h0, 8'h51);
    send_pix(1, 8'h60, 1'b0, 1'b1, 4'h0, 8'h62);
    send_pix(1, 8'h70, 1'b0, 1'b1, 4'h0, 8'h71);
    send_pix(1, 8'h8C, 1'b1, 1'b0, 4'h0, 8'h8C);
    wait_done(1, 1'b0);

    start_frame(1, 1'b0, 16'd4, 9'd1);
    send_pix(1, 8'h00, 1'b0, 1'b1, 4'h0, 8'h01);
    send_pix(1, 8'hF0, 1'b1, 1'b1, 4'h0, 8'hF1);
    wait_done(1, 1'b1);

    start_frame(1, 1'b1, 16'd0, 9'd1);
    send_pix(1, 8'h3C, 1'b1, 1'b0, 4'h0, 8'h3C);
    wait_done(1, 1'b0);

    repeat (3) @(posedge clk);
    checks++;
    if (pq0.size() + pq1.size() + tq1.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d expected items never seen", pq0.size() + pq1.size() + tq1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
